// File: rtl/streaming_accumulator.sv
// -----------------------------------------------------------------------------
// streaming_accumulator
//
// Purpose:
//   Free-running accumulator. Every rising clock edge adds the unsigned input
//   sample to a running sum and bumps a sample counter. The sum wraps modulo
//   2^SUM_W, and a sticky flag records that a wrap has occurred. All outputs
//   are driven directly from registers.
//
// Parameters:
//   DATA_W        width of the input sample (unsigned)
//   SUM_W         width of the running sum and sample counter (SUM_W >= DATA_W)
//
// Ports:
//   clk           rising-edge clock for all state
//   reset         asynchronous, active-high; clears sum, count and overflow
//   data_in       sample added on every edge (zero-extended, never sign-extended)
//   sum_out       registered running sum since the last reset
//   overflow      sticky; set on any edge whose addition carries out of SUM_W
//   sample_count  registered number of edges accumulated since the last reset
// -----------------------------------------------------------------------------
module streaming_accumulator #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SUM_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    output logic [SUM_W-1:0]  sum_out,
    output logic              overflow,
    output logic [SUM_W-1:0]  sample_count
);

    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic [SUM_W-1:0] cnt_q;
    logic [SUM_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             carry;

    always_comb begin
        // One extra bit on the adder captures the carry-out that marks a wrap.
        {carry, sum_d} = {1'b0, sum_q} + {1'b0, SUM_W'(data_in)};
        // Counter wrap is deliberately not fed into the overflow flag.
        cnt_d = cnt_q + SUM_W'(1);
        ovf_d = ovf_q | carry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum_out      = sum_q;
    assign sample_count = cnt_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_streaming_accumulator.sv
// -----------------------------------------------------------------------------
// tb_streaming_accumulator
//
// Self-checking bench for streaming_accumulator with default parameters.
// A reference model tracks the expected sum, count and overflow flag using
// 64-bit arithmetic and modulo reduction; directed scenarios are followed by
// randomized samples with occasional reset pulses.
// -----------------------------------------------------------------------------
module tb_streaming_accumulator;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned SUM_W  = 32;
    localparam logic [63:0] MOD    = 64'h1_0000_0000;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] data_in;
    logic [SUM_W-1:0]  sum_out;
    logic              overflow;
    logic [SUM_W-1:0]  sample_count;

    int unsigned n_checks;
    int unsigned n_errors;

    // Reference model state
    logic [63:0] m_sum;
    logic [63:0] m_cnt;
    logic        m_ovf;

    streaming_accumulator #(
        .DATA_W(DATA_W),
        .SUM_W (SUM_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .sum_out     (sum_out),
        .overflow    (overflow),
        .sample_count(sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".sum"}, 64'(sum_out), m_sum);
        check({tag, ".cnt"}, 64'(sample_count), m_cnt);
        check({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    endtask

    // Behaviour of one rising edge, from the value present at that edge.
    task automatic model_edge(input logic [63:0] d, input logic r);
        logic [63:0] t;
        if (r) begin
            m_sum = '0;
            m_cnt = '0;
            m_ovf = 1'b0;
        end else begin
            t     = m_sum + d;
            m_ovf = m_ovf | (t >= MOD);
            m_sum = t % MOD;
            m_cnt = (m_cnt + 1) % MOD;
        end
    endtask

    // Drive inputs on the falling edge, let the rising edge happen, then
    // sample 1 ns later.
    task automatic tick(input logic [DATA_W-1:0] d, input logic r, input bit do_check, input string tag);
        @(negedge clk);
        data_in = d;
        reset   = r;
        @(posedge clk);
        model_edge(64'(d), r);
        #1;
        if (do_check) check_all(tag);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_sum    = '0;
        m_cnt    = '0;
        m_ovf    = 1'b0;
        reset    = 1'b1;
        data_in  = 16'h5A5A;

        // Reset held over the first edge: the sample there must be dropped.
        @(posedge clk);
        model_edge(64'h5A5A, 1'b1);
        #1;
        check_all("reset_state");

        // Ramp 1..16
        for (int i = 1; i <= 16; i++) tick(DATA_W'(i), 1'b0, 1'b1, "ramp");
        check("ramp.sum136", 64'(sum_out), 64'd136);
        check("ramp.cnt16", 64'(sample_count), 64'd16);
        check("ramp.ovf0", 64'(overflow), 64'd0);

        // Zero samples: sum holds, count advances
        tick(16'h1234, 1'b1, 1'b1, "rst_a");
        for (int i = 0; i < 5; i++) tick('0, 1'b0, 1'b1, "zeros");
        check("zeros.sum0", 64'(sum_out), 64'd0);
        check("zeros.cnt5", 64'(sample_count), 64'd5);

        // No sign extension
        tick('0, 1'b1, 1'b0, "rst_b");
        for (int i = 0; i < 3; i++) tick(16'hFFFF, 1'b0, 1'b1, "ffff");
        check("ffff.sum", 64'(sum_out), 64'h0002_FFFD);

        // Asynchronous mid-stream reset between edges
        tick('0, 1'b1, 1'b0, "rst_c");
        for (int i = 1; i <= 3; i++) tick(DATA_W'(i), 1'b0, 1'b1, "pre_async");
        check("pre_async.sum6", 64'(sum_out), 64'd6);
        #2;
        reset = 1'b1;
        #1;
        model_edge(64'd0, 1'b1);
        check_all("async_rst");
        check("async_rst.sum0", 64'(sum_out), 64'd0);
        tick(16'd5, 1'b0, 1'b1, "after_async");
        check("after_async.sum5", 64'(sum_out), 64'd5);

        // Glitchy input between edges: only the value at the edge counts
        tick('0, 1'b1, 1'b0, "rst_d");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            data_in = 16'd7;
            reset   = 1'b0;
            @(posedge clk);
            model_edge(64'd7, 1'b0);
            #1;
            check_all("toggle");
            #2;
            data_in = 16'd100;
        end
        check("toggle.sum28", 64'(sum_out), 64'd28);

        // Wrap: preload to 0xFFFF_FFF0 then add 0x20
        tick('0, 1'b1, 1'b0, "rst_e");
        for (int i = 0; i < 65536; i++) tick(16'hFFFF, 1'b0, 1'b0, "preload");
        tick(16'hFFF0, 1'b0, 1'b1, "trim");
        check("trim.sum", 64'(sum_out), 64'hFFFF_FFF0);
        check("trim.ovf0", 64'(overflow), 64'd0);
        tick(16'h0020, 1'b0, 1'b1, "wrap");
        check("wrap.sum", 64'(sum_out), 64'h0000_0010);
        check("wrap.ovf1", 64'(overflow), 64'd1);
        for (int i = 0; i < 4; i++) tick(DATA_W'($urandom), 1'b0, 1'b1, "sticky");
        check("sticky.ovf1", 64'(overflow), 64'd1);

        // Randomized samples with occasional reset pulses
        for (int i = 0; i < 300; i++) begin
            logic r;
            r = ($urandom_range(0, 19) == 0);
            tick(DATA_W'($urandom), r, 1'b1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
